// File: rtl/matrix_seq.sv
// Matrix instruction sequencer: loads A (and B) from byte memory, runs the external ALU, stores the result.
// Latency binary/unary/det = 80/54/30 cycles with a 1-cycle ALU; start is ignored while busy, no queueing.
module matrix_seq #(
  parameter int N_ELEM       = 25,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            instr_op,
  input  logic [7:0]            instr_addr_a,
  input  logic [7:0]            instr_addr_b,
  input  logic [7:0]            instr_addr_c,
  input  logic [7:0]            instr_scalar,
  output logic [7:0]            mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic [3:0]            ula_opcode,
  output logic [7:0]            ula_escalar,
  output logic [N_ELEM*8-1:0]   ula_matriz_a,
  output logic [N_ELEM*8-1:0]   ula_matriz_b,
  input  logic [N_ELEM*8-1:0]   ula_result,
  input  logic                  ula_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_MAX = (N_ELEM > EXEC_TIMEOUT) ? N_ELEM : EXEC_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_LAST_LD = CW'(N_ELEM);
  localparam logic [CW-1:0] C_LAST_ST = CW'(N_ELEM - 1);
  localparam logic [CW-1:0] C_LAST_EX = CW'(EXEC_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_FIN} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_op;
  logic [7:0]          r_addr_a, r_addr_b, r_addr_c, r_scalar;
  logic                r_err;
  logic [N_ELEM*8-1:0] r_mat_a, r_mat_b, r_res;
  logic                w_legal, w_binary, w_det;
  logic [CW-1:0]       w_last_st;

  assign w_legal   = (instr_op >= 4'd3) && (instr_op <= 4'd12);
  assign w_binary  = (r_op >= 4'd3) && (r_op <= 4'd5);
  assign w_det     = (r_op >= 4'd9) && (r_op <= 4'd12);
  assign w_last_st = w_det ? {CW{1'b0}} : C_LAST_ST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = w_legal ? S_LOAD_A : S_FIN;
      S_LOAD_A: if (r_cnt == C_LAST_LD) w_next = w_binary ? S_LOAD_B : S_EXEC;
      S_LOAD_B: if (r_cnt == C_LAST_LD) w_next = S_EXEC;
      // done in the first EXEC cycle may be stale, so it only counts from cycle 1 on
      S_EXEC: begin
        if ((r_cnt != '0) && ula_done) w_next = S_STORE;
        else if (r_cnt == C_LAST_EX)   w_next = S_FIN;
      end
      S_STORE:  if (r_cnt == w_last_st) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_scalar <= '0;
      r_err    <= 1'b0;
      r_mat_a  <= '0;
      r_mat_b  <= '0;
      r_res    <= '0;
    end else begin
      r_cnt <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_op     <= instr_op;
          r_addr_a <= instr_addr_a;
          r_addr_b <= instr_addr_b;
          r_addr_c <= instr_addr_c;
          r_scalar <= instr_scalar;
          r_err    <= !w_legal;
          r_mat_a  <= '0;
          r_mat_b  <= '0;
          r_res    <= '0;
        end
        // read data lags the address by one cycle
        S_LOAD_A: if (r_cnt != '0) r_mat_a[8*(int'(r_cnt)-1) +: 8] <= mem_rdata;
        S_LOAD_B: if (r_cnt != '0) r_mat_b[8*(int'(r_cnt)-1) +: 8] <= mem_rdata;
        S_EXEC: begin
          if ((r_cnt != '0) && ula_done) r_res <= ula_result;
          else if (r_cnt == C_LAST_EX)   r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ula_opcode = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      S_LOAD_A: if (r_cnt < C_LAST_LD) begin
        mem_rd   = 1'b1;
        mem_addr = r_addr_a + 8'(r_cnt);
      end
      S_LOAD_B: if (r_cnt < C_LAST_LD) begin
        mem_rd   = 1'b1;
        mem_addr = r_addr_b + 8'(r_cnt);
      end
      S_EXEC:   ula_opcode = r_op;
      S_STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = r_addr_c + 8'(r_cnt);
        mem_wdata = r_res[8*int'(r_cnt) +: 8];
      end
      S_FIN: begin
        done = 1'b1;
        err  = r_err;
      end
      default: ;
    endcase
  end

  assign ula_escalar  = r_scalar;
  assign ula_matriz_a = r_mat_a;
  assign ula_matriz_b = r_mat_b;

endmodule

// File: tb/tb_matrix_seq.sv
// Bench for matrix_seq: byte memory and registered ALU models, reference model of expected traffic and latency.
module tb_matrix_seq;
  localparam int N   = 25;
  localparam int TMO = 15;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] instr_op = '0;
  logic [7:0] instr_addr_a = '0, instr_addr_b = '0, instr_addr_c = '0, instr_scalar = '0;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_rd, mem_wr;
  logic [3:0] ula_opcode;
  logic [7:0] ula_escalar;
  logic [N*8-1:0] ula_matriz_a, ula_matriz_b;
  logic [N*8-1:0] ula_result = '0;
  logic       ula_done = 1'b0;
  logic       busy, done, err;

  int total = 0, bad = 0;

  matrix_seq #(.N_ELEM(N), .EXEC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_op(instr_op),
    .instr_addr_a(instr_addr_a), .instr_addr_b(instr_addr_b), .instr_addr_c(instr_addr_c),
    .instr_scalar(instr_scalar), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ula_opcode(ula_opcode),
    .ula_escalar(ula_escalar), .ula_matriz_a(ula_matriz_a), .ula_matriz_b(ula_matriz_b),
    .ula_result(ula_result), .ula_done(ula_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Byte memory, 1-cycle read latency, with an access log
  logic [7:0] mem [256];
  logic       mem_fill = 1'b0;
  logic [7:0] rd_log[$], wr_addr_log[$], wr_dat_log[$];
  int         excl_cnt = 0;
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_log.push_back(mem_addr);
      wr_dat_log.push_back(mem_wdata);
    end
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end
    if (mem_rd && mem_wr) excl_cnt++;
  end

  function automatic logic [7:0] alu_byte(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] s, input int k);
    return 8'(a + 3 * b + k) ^ s ^ {op, op};
  endfunction

  function automatic logic [N*8-1:0] alu_calc(input logic [3:0] op, input logic [N*8-1:0] ma,
                                              input logic [N*8-1:0] mb, input logic [7:0] s);
    logic [N*8-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[8*k +: 8] = alu_byte(op, ma[8*k +: 8], mb[8*k +: 8], s, k);
    return r;
  endfunction

  // Registered ALU: raises done alu_delay cycles after a nonzero opcode appears, clears on opcode 0
  int         alu_delay = 1;
  bit         alu_never = 1'b0;
  int         alu_cnt = 0;
  int         bnz_cnt = 0;
  logic [7:0] esc_seen = '0;
  always @(posedge clk) begin
    if (ula_opcode == 4'd0) begin
      ula_done <= 1'b0;
      alu_cnt  <= 0;
    end else begin
      if (ula_matriz_b != '0) bnz_cnt++;
      esc_seen <= ula_escalar;
      alu_cnt  <= alu_cnt + 1;
      if (!alu_never && (alu_cnt + 1 >= alu_delay)) begin
        ula_done   <= 1'b1;
        ula_result <= alu_calc(ula_opcode, ula_matriz_a, ula_matriz_b, ula_escalar);
      end
    end
  end

  // Reference model: expected reads, writes, latency and error for one instruction
  logic [7:0] exp_rd[$], exp_wa[$], exp_wd[$];
  int         exp_lat;
  bit         exp_err;
  task automatic model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] s, input int dly, input bit never);
    logic [7:0] ea[N], eb[N];
    bit legal, bin, det;
    int nexec, nst;
    legal = (op >= 3) && (op <= 12);
    bin   = legal && (op <= 5);
    det   = legal && (op >= 9);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    if (!legal) begin
      exp_lat = 1;
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < N; k++) begin
      ea[k] = mem[8'(a + k)];
      exp_rd.push_back(8'(a + k));
    end
    for (int k = 0; k < N; k++) begin
      eb[k] = bin ? mem[8'(b + k)] : 8'h00;
      if (bin) exp_rd.push_back(8'(b + k));
    end
    if (!never && (dly + 1 <= TMO)) begin
      nexec = dly + 1; nst = det ? 1 : N; exp_err = 1'b0;
    end else begin
      nexec = TMO; nst = 0; exp_err = 1'b1;
    end
    for (int k = 0; k < nst; k++) begin
      exp_wa.push_back(8'(c + k));
      exp_wd.push_back(alu_byte(op, ea[k], eb[k], s, k));
    end
    exp_lat = (N + 1) + (bin ? N + 1 : 0) + nexec + nst + 1;
  endtask

  // -1 on a count mismatch, else the number of differing entries
  function automatic int rd_diff(input int base);
    int n;
    n = 0;
    if (rd_log.size() - base != exp_rd.size()) return -1;
    for (int i = 0; i < exp_rd.size(); i++) if (rd_log[base+i] !== exp_rd[i]) n++;
    return n;
  endfunction

  function automatic int wr_diff(input int base);
    int n;
    n = 0;
    if (wr_addr_log.size() - base != exp_wa.size()) return -1;
    for (int i = 0; i < exp_wa.size(); i++)
      if (wr_addr_log[base+i] !== exp_wa[i] || wr_dat_log[base+i] !== exp_wd[i]) n++;
    return n;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] s, input int dly, input bit never,
                        output int lat, output logic err_at_done, output logic done_after);
    alu_delay = dly;
    alu_never = never;
    @(negedge clk);
    instr_op = op; instr_addr_a = a; instr_addr_b = b; instr_addr_c = c; instr_scalar = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    instr_op = 4'($urandom); instr_addr_a = 8'($urandom); instr_addr_b = 8'($urandom);
    instr_addr_c = 8'($urandom); instr_scalar = 8'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    err_at_done = err;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    mem_fill = 1'b1;
    repeat (2) @(negedge clk);
    mem_fill = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_done_err got=%b%b want=00", done, err); end
    total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL rst_rdwr got=%b%b want=00", mem_rd, mem_wr); end
    total++; if (ula_opcode !== 4'h0) begin bad++; $display("FAIL rst_opcode got=%h want=0", ula_opcode); end
    total++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_addr_wdata got=%h/%h want=00/00", mem_addr, mem_wdata); end
    total++; if (ula_matriz_a !== '0 || ula_matriz_b !== '0 || ula_escalar !== 8'h00) begin bad++; $display("FAIL rst_operands got nonzero want=0"); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_binary();
    int lat, rb, wb;
    logic e, da;
    logic [7:0] s;
    s = 8'($urandom);
    rb = rd_log.size(); wb = wr_addr_log.size();
    model_op(4'b0011, 8'h10, 8'h40, 8'h80, s, 1, 1'b0);
    fork
      run_op(4'b0011, 8'h10, 8'h40, 8'h80, s, 1, 1'b0, lat, e, da);
      begin
        repeat (40) @(negedge clk);
        instr_op = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    total++; if (lat !== 80) begin bad++; $display("FAIL bin_latency got=%0d want=80", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL bin_err got=%b want=0", e); end
    total++; if (rd_diff(rb) !== 0) begin bad++; $display("FAIL bin_reads diff=%0d want=0 (n=%0d)", rd_diff(rb), rd_log.size() - rb); end
    total++; if (wr_diff(wb) !== 0) begin bad++; $display("FAIL bin_writes diff=%0d want=0 (n=%0d)", wr_diff(wb), wr_addr_log.size() - wb); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL bin_done_pulse got=%b want=0", da); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bin_no_queue busy got=%b want=0", busy); end
  endtask

  task automatic test_unary_wrap();
    int lat, rb, wb, bz;
    logic e, da;
    logic [7:0] s;
    s = 8'($urandom);
    rb = rd_log.size(); wb = wr_addr_log.size(); bz = bnz_cnt;
    model_op(4'b0110, 8'hF0, 8'h55, 8'h30, s, 1, 1'b0);
    run_op(4'b0110, 8'hF0, 8'h55, 8'h30, s, 1, 1'b0, lat, e, da);
    total++; if (lat !== 54) begin bad++; $display("FAIL un_latency got=%0d want=54", lat); end
    total++; if (rd_diff(rb) !== 0) begin bad++; $display("FAIL un_wrap_reads diff=%0d want=0", rd_diff(rb)); end
    total++; if (bnz_cnt - bz !== 0) begin bad++; $display("FAIL un_matriz_b_zero got=%0d nonzero cycles want=0", bnz_cnt - bz); end
    total++; if (wr_diff(wb) !== 0) begin bad++; $display("FAIL un_writes diff=%0d want=0", wr_diff(wb)); end
    total++; if (esc_seen !== s) begin bad++; $display("FAIL un_escalar got=%h want=%h", esc_seen, s); end
  endtask

  task automatic test_determinant();
    int lat, wb;
    logic e, da;
    logic [7:0] s;
    s = 8'($urandom);
    wb = wr_addr_log.size();
    model_op(4'b1001, 8'h60, 8'h00, 8'h20, s, 1, 1'b0);
    run_op(4'b1001, 8'h60, 8'h00, 8'h20, s, 1, 1'b0, lat, e, da);
    total++; if (lat !== 30) begin bad++; $display("FAIL det_latency got=%0d want=30", lat); end
    total++; if (wr_addr_log.size() - wb !== 1) begin bad++; $display("FAIL det_write_count got=%0d want=1", wr_addr_log.size() - wb); end
    total++; if (wr_diff(wb) !== 0) begin bad++; $display("FAIL det_write diff=%0d want=0", wr_diff(wb)); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL det_err got=%b want=0", e); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops[4];
    int lat, rb, wb;
    logic e, da;
    ops = '{4'b0000, 4'b1111, 4'b0010, 4'b1101};
    foreach (ops[i]) begin
      rb = rd_log.size(); wb = wr_addr_log.size();
      run_op(ops[i], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, lat, e, da);
      total++; if (lat !== 1) begin bad++; $display("FAIL ill_latency op=%h got=%0d want=1", ops[i], lat); end
      total++; if (e !== 1'b1) begin bad++; $display("FAIL ill_err op=%h got=%b want=1", ops[i], e); end
      total++; if (rd_log.size() != rb || wr_addr_log.size() != wb) begin bad++; $display("FAIL ill_mem op=%h got rd=%0d wr=%0d want 0/0", ops[i], rd_log.size() - rb, wr_addr_log.size() - wb); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL ill_pulse op=%h got=%b want=0", ops[i], da); end
    end
  endtask

  task automatic test_timeout();
    int dl[3], lat, wb;
    logic e, da;
    dl = '{14, 15, 100};
    foreach (dl[i]) begin
      wb = wr_addr_log.size();
      model_op(4'b0100, 8'h05, 8'hC0, 8'hE0, 8'h3C, dl[i], dl[i] == 100);
      run_op(4'b0100, 8'h05, 8'hC0, 8'hE0, 8'h3C, dl[i], dl[i] == 100, lat, e, da);
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL tmo_latency dly=%0d got=%0d want=%0d", dl[i], lat, exp_lat); end
      total++; if (e !== exp_err) begin bad++; $display("FAIL tmo_err dly=%0d got=%b want=%b", dl[i], e, exp_err); end
      total++; if (wr_diff(wb) !== 0) begin bad++; $display("FAIL tmo_writes dly=%0d diff=%0d want=0", dl[i], wr_diff(wb)); end
    end
  endtask

  task automatic test_random();
    int lat, rb, wb, dly;
    logic e, da;
    logic [3:0] op;
    logic [7:0] a, b, c, s;
    for (int it = 0; it < 12; it++) begin
      op = 4'($urandom_range(3, 12));
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); s = 8'($urandom);
      dly = int'($urandom_range(1, 4));
      rb = rd_log.size(); wb = wr_addr_log.size();
      model_op(op, a, b, c, s, dly, 1'b0);
      run_op(op, a, b, c, s, dly, 1'b0, lat, e, da);
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency op=%h dly=%0d got=%0d want=%0d", op, dly, lat, exp_lat); end
      total++; if (e !== exp_err) begin bad++; $display("FAIL rnd_err op=%h got=%b want=%b", op, e, exp_err); end
      total++; if (rd_diff(rb) !== 0) begin bad++; $display("FAIL rnd_reads op=%h a=%h b=%h diff=%0d want=0", op, a, b, rd_diff(rb)); end
      total++; if (wr_diff(wb) !== 0) begin bad++; $display("FAIL rnd_writes op=%h c=%h diff=%0d want=0", op, c, wr_diff(wb)); end
    end
    total++; if (excl_cnt !== 0) begin bad++; $display("FAIL rd_wr_exclusive got=%0d overlaps want=0", excl_cnt); end
  endtask

  task automatic test_reset_mid_store();
    int n, rb, wb, rb2;
    alu_delay = 1; alu_never = 1'b0;
    rb = rd_log.size(); wb = wr_addr_log.size();
    @(negedge clk);
    instr_op = 4'b0011; instr_addr_a = 8'h00; instr_addr_b = 8'h19; instr_addr_c = 8'hA0; instr_scalar = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    instr_op = 4'b0000; instr_addr_c = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_wr === 1'b1 && mem_addr === 8'hAA) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 200) begin bad++; $display("FAIL rs_reach_store got=timeout want=write at aa"); end
    total++; if (wr_addr_log.size() - wb !== 10) begin bad++; $display("FAIL rs_writes_before got=%0d want=10", wr_addr_log.size() - wb); end
    total++; if (wr_addr_log.size() > wb && wr_addr_log[wb] !== 8'hA0) begin bad++; $display("FAIL rs_first_addr got=%h want=a0", wr_addr_log[wb]); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin bad++; $display("FAIL rs_async_wr got=%b%b want=00", mem_wr, mem_rd); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rs_async_busy got=%b%b want=00", busy, done); end
    total++; if (mem_addr !== 8'h00 || ula_opcode !== 4'h0) begin bad++; $display("FAIL rs_async_addr got=%h/%h want=00/0", mem_addr, ula_opcode); end
    rb2 = rd_log.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (wr_addr_log.size() - wb !== 10) begin bad++; $display("FAIL rs_no_more_writes got=%0d want=10", wr_addr_log.size() - wb); end
    total++; if (rd_log.size() !== rb2 || busy !== 1'b0) begin bad++; $display("FAIL rs_idle_after got rd=%0d busy=%b want 0/0", rd_log.size() - rb2, busy); end
    total++; if (rb2 - rb !== 2 * N) begin bad++; $display("FAIL rs_reads got=%0d want=%0d", rb2 - rb, 2 * N); end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_unary_wrap();
    test_determinant();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_seq.md
MATRIX_SEQ -- requirements
Module: matrix_seq

Interface
REQ-001 SHALL have parameter N_ELEM, default 25: matrix elements per operand, 5x5 of 8 bits.
REQ-002 SHALL have parameter EXEC_TIMEOUT, default 15: maximum EXEC cycles allowed while waiting for ula_done.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: instruction request, sampled only in IDLE.
REQ-006 SHALL have port instr_op, input, 4: ALU opcode.
REQ-007 SHALL have ports instr_addr_a, instr_addr_b and instr_addr_c, input, 8 each: base addresses of A, B and the result.
REQ-008 SHALL have port instr_scalar, input, 8: scalar operand.
REQ-009 SHALL have ports mem_addr (output, 8), mem_rd (output, 1), mem_wr (output, 1), mem_wdata (output, 8) and mem_rdata (input, 8): byte memory with a fixed read latency of 1 cycle.
REQ-010 SHALL have ports ula_opcode (output, 4), ula_escalar (output, 8), ula_matriz_a (output, 200) and ula_matriz_b (output, 200): ALU operands, element k at bits [8k+7:8k].
REQ-011 SHALL have ports ula_result (input, 200) and ula_done (input, 1): ALU result and completion flag; the ALU is registered and clears done when the opcode is 0000.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse, coincident with done).

Function
REQ-013 SHALL implement the states IDLE, LOAD_A, LOAD_B, EXEC, STORE and FIN.
REQ-014 SHALL, in IDLE with start=1, latch all instr_* inputs and leave IDLE: to LOAD_A for a legal opcode, to FIN with err for an illegal one.
REQ-015 SHALL treat opcodes 0011-0101 as binary; 0110-1000 as unary with a full 25-element result; 1001-1100 as determinant with a 1-element result; 0000-0010 and 1101-1111 as illegal.
REQ-016 SHALL, in LOAD_A, assert mem_rd with mem_addr = addr_a+k for k=0..24 in state cycles 0..24, and write mem_rdata into element k in state cycle k+1, for exactly 26 cycles.
REQ-017 SHALL perform LOAD_B identically from addr_b for binary opcodes only; for all other opcodes SHALL skip LOAD_B and hold ula_matriz_b at zero.
REQ-018 SHALL compute all addresses modulo 256 (0xFF+1 wraps to 0x00).
REQ-019 SHALL drive ula_opcode with the latched opcode only in EXEC and with 0000 in every other state; ula_escalar SHALL equal the latched scalar.
REQ-020 SHALL, in EXEC, ignore ula_done in the first EXEC cycle.
REQ-021 SHALL, from the second EXEC cycle on, latch ula_result and go to STORE on the first cycle with ula_done=1.
REQ-022 SHALL, if ula_done is not seen within EXEC_TIMEOUT EXEC cycles, go to FIN with err=1 and perform no writes.
REQ-023 SHALL, in STORE, assert mem_wr with mem_addr = addr_c+k and mem_wdata = result element k, one write per cycle: k=0..24 for full results, k=0 only for determinant opcodes.
REQ-024 SHALL, in FIN, pulse done for 1 cycle (with err if applicable) and then return to IDLE.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL ignore start while busy=1, so that no instruction is queued.
REQ-027 SHALL keep mem_rd and mem_wr mutually exclusive and never assert either outside LOAD_A, LOAD_B or STORE.
REQ-028 SHALL give a binary operation with ula_done in EXEC cycle 1 a latency of 80 cycles from the accepting edge to done: 26+26+2+25+1.
REQ-029 SHALL give a unary full-result operation a latency of 54 cycles and a determinant operation a latency of 30 cycles, under the same ula_done timing.

Reset
REQ-030 SHALL, on rst_n=0, immediately force state to IDLE and busy, done, err, mem_rd and mem_wr to 0, independent of clk.
REQ-031 SHALL, on rst_n=0, force ula_opcode to 0000, mem_addr and mem_wdata to 0x00, and all operand and result registers to zero.
REQ-032 SHALL abort any operation in progress when reset asserts, with no further writes after reset, including mid-STORE.

Verification
REQ-033 SHALL cover a binary opcode: op=0011, A at 0x10, B at 0x40, C at 0x80, ALU model done after 1 cycle -> 25 reads from A, 25 reads from B, 25 writes at 0x80-0x98, done exactly 80 cycles after start.
REQ-034 SHALL cover a unary opcode with wrap: op=0110, addr_a=0xF0 -> reads at 0xF0-0xFF then 0x00-0x08, no B reads, ula_matriz_b=0.
REQ-035 SHALL cover a determinant opcode: op=1001, addr_c=0x20 -> exactly one write at 0x20 carrying result element 0, done at cycle 30.
REQ-036 SHALL cover illegal opcodes: op=0000 and op=1111 -> done and err pulsed 1 cycle after start, no memory accesses.
REQ-037 SHALL cover the timeout: ALU model never raises done -> err after 15 EXEC cycles, zero writes.
REQ-038 SHALL cover reset during STORE at k=10 and a start pulse while busy: mem_wr drops asynchronously, busy=0; the second start is ignored.
